// File: rtl/aes_req_rsp_ctrl.sv
// Request/response controller for the pipelined AES core: serialises plaintext+key
// jobs into 64-bit request words and reassembles 64-bit response words into results.
module aes_req_rsp_ctrl #(
  parameter int NUM_REQ_WORDS   = 4,
  parameter int NUM_RSP_WORDS   = 22,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [127:0] job_data,
  input  logic [127:0] job_key,
  output logic         req_valid,
  input  logic         req_ready,
  output logic [63:0]  req_data,
  input  logic         rsp_valid,
  output logic         rsp_ready,
  input  logic [63:0]  rsp_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic [127:0] res_last_rkey,
  output logic [3:0]   outstanding,
  output logic         err_unexpected,
  output logic [15:0]  res_count
);

  localparam int TXW = $clog2(NUM_REQ_WORDS) + 1;
  localparam int RXW = $clog2(NUM_RSP_WORDS) + 1;
  localparam logic [TXW-1:0] TX_LAST    = TXW'(NUM_REQ_WORDS - 1);
  localparam logic [RXW-1:0] RX_LAST    = RXW'(NUM_RSP_WORDS - 1);
  localparam logic [RXW-1:0] RX_RKEY_LO = RXW'(NUM_RSP_WORDS - 2);
  localparam logic [3:0]     MAX_OUT    = 4'(MAX_OUTSTANDING);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
  typedef enum logic {RX_COLLECT, RX_OUT} rx_state_e;

  tx_state_e      tx_state_q, tx_state_d;
  rx_state_e      rx_state_q, rx_state_d;
  logic [TXW-1:0] tx_cnt_q, tx_cnt_d, tx_cnt_inc_s;
  logic [RXW-1:0] rx_cnt_q, rx_cnt_d;
  logic [127:0]   job_data_q, job_data_d, job_key_q, job_key_d;
  logic [63:0]    req_data_q, req_data_d;
  logic [127:0]   res_data_q, res_data_d, res_rkey_q, res_rkey_d;
  logic [3:0]     outstanding_q, outstanding_d;
  logic           err_q, err_d;
  logic [15:0]    res_count_q, res_count_d;
  logic           tx_done_s, res_done_s, rsp_hs_s, unexp_s;

  function automatic logic [63:0] req_word(input logic [TXW-1:0] idx,
                                           input logic [127:0] d,
                                           input logic [127:0] k);
    logic [63:0] w;
    case (idx)
      TXW'(0): w = d[127:64];
      TXW'(1): w = d[63:0];
      TXW'(2): w = k[127:64];
      TXW'(3): w = k[63:0];
      default: w = 64'h0;
    endcase
    return w;
  endfunction

  assign job_ready      = (tx_state_q == TX_IDLE) && (outstanding_q < MAX_OUT);
  assign req_valid      = (tx_state_q == TX_SEND);
  assign req_data       = req_data_q;
  assign rsp_ready      = (rx_state_q == RX_COLLECT);
  assign res_valid      = (rx_state_q == RX_OUT);
  assign res_data       = res_data_q;
  assign res_last_rkey  = res_rkey_q;
  assign outstanding    = outstanding_q;
  assign err_unexpected = err_q;
  assign res_count      = res_count_q;

  assign tx_cnt_inc_s = tx_cnt_q + TXW'(1);
  assign rsp_hs_s     = rsp_valid && rsp_ready;
  // A word arriving with nothing in flight and no collection started is a protocol error.
  assign unexp_s      = rsp_hs_s && (rx_cnt_q == RXW'(0)) && (outstanding_q == 4'd0);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    job_data_d = job_data_q;
    job_key_d  = job_key_q;
    req_data_d = req_data_q;
    tx_done_s  = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (job_valid && job_ready) begin
          job_data_d = job_data;
          job_key_d  = job_key;
          tx_cnt_d   = TXW'(0);
          req_data_d = req_word(TXW'(0), job_data, job_key);
          tx_state_d = TX_SEND;
        end else begin
          req_data_d = 64'h0;
        end
      end
      TX_SEND: begin
        if (req_ready && (tx_cnt_q == TX_LAST)) begin
          tx_cnt_d   = tx_cnt_inc_s;
          tx_done_s  = 1'b1;
          req_data_d = 64'h0;
          tx_state_d = TX_IDLE;
        end else if (req_ready) begin
          tx_cnt_d   = tx_cnt_inc_s;
          req_data_d = req_word(tx_cnt_inc_s, job_data_q, job_key_q);
        end else begin
          tx_cnt_d = tx_cnt_q;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        req_data_d = 64'h0;
      end
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    res_data_d = res_data_q;
    res_rkey_d = res_rkey_q;
    res_done_s = 1'b0;
    case (rx_state_q)
      RX_COLLECT: begin
        if (rsp_hs_s && !unexp_s) begin
          if (rx_cnt_q == RXW'(0))          res_data_d[63:0]   = rsp_data;
          else if (rx_cnt_q == RXW'(1))     res_data_d[127:64] = rsp_data;
          else if (rx_cnt_q == RX_RKEY_LO)  res_rkey_d[63:0]   = rsp_data;
          else if (rx_cnt_q == RX_LAST)     res_rkey_d[127:64] = rsp_data;
          else                              res_data_d         = res_data_q;
          if (rx_cnt_q == RX_LAST) begin
            rx_cnt_d   = RXW'(0);
            rx_state_d = RX_OUT;
          end else begin
            rx_cnt_d = rx_cnt_q + RXW'(1);
          end
        end else begin
          rx_cnt_d = rx_cnt_q;
        end
      end
      RX_OUT: begin
        if (res_ready) begin
          res_done_s = 1'b1;
          rx_state_d = RX_COLLECT;
        end else begin
          rx_state_d = RX_OUT;
        end
      end
      default: rx_state_d = RX_COLLECT;
    endcase
  end

  // Shared bookkeeping: in-flight count (saturating both ways), sticky error, result counter.
  always_comb begin
    outstanding_d = outstanding_q;
    if (tx_done_s && !res_done_s) begin
      outstanding_d = (outstanding_q < MAX_OUT) ? outstanding_q + 4'd1 : outstanding_q;
    end else if (res_done_s && !tx_done_s) begin
      outstanding_d = (outstanding_q != 4'd0) ? outstanding_q - 4'd1 : outstanding_q;
    end else begin
      outstanding_d = outstanding_q;
    end
    err_d       = err_q | unexp_s;
    res_count_d = res_done_s ? res_count_q + 16'd1 : res_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q    <= TX_IDLE;
      rx_state_q    <= RX_COLLECT;
      tx_cnt_q      <= TXW'(0);
      rx_cnt_q      <= RXW'(0);
      job_data_q    <= 128'h0;
      job_key_q     <= 128'h0;
      req_data_q    <= 64'h0;
      res_data_q    <= 128'h0;
      res_rkey_q    <= 128'h0;
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
      res_count_q   <= 16'd0;
    end else begin
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      job_data_q    <= job_data_d;
      job_key_q     <= job_key_d;
      req_data_q    <= req_data_d;
      res_data_q    <= res_data_d;
      res_rkey_q    <= res_rkey_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      res_count_q   <= res_count_d;
    end
  end

endmodule
